// File: rtl/layer2_window_fetch.sv
// rtl/layer2_window_fetch.sv - layer-2 3x3 window fetch, two taps per beat over 8 pooled channels
`timescale 1ns/1ps
module layer2_window_fetch #(
    parameter int IN_DIM     = 14,
    parameter int K          = 3,
    parameter int ROW_STRIDE = 56,
    parameter int COL_STRIDE = 2,
    parameter int CH         = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    input  logic            win_ready,
    output logic            mem_load,
    output logic [9:0]      mem_addr1,
    output logic [9:0]      mem_addr2,
    input  logic [8*CH-1:0] mem_rd1,
    input  logic [8*CH-1:0] mem_rd2,
    output logic            beat_valid,
    output logic            beat_first,
    output logic            beat_last,
    output logic            b_valid,
    output logic [3:0]      tap_idx_a,
    output logic [3:0]      tap_idx_b,
    output logic [3:0]      win_row,
    output logic [3:0]      win_col,
    output logic [8*CH-1:0] tap_a,
    output logic [8*CH-1:0] tap_b
);
    localparam int         OUT_DIM   = IN_DIM - K + 1;
    localparam logic [3:0] LAST_POS  = 4'(OUT_DIM - 1);
    localparam logic [2:0] LAST_BEAT = 3'd4;
    localparam logic [9:0] ROW_W     = 10'(ROW_STRIDE);
    localparam logic [9:0] COL_W     = 10'(COL_STRIDE);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE, S_DRAIN} state_t;

    state_t     state, state_n;
    logic [3:0] r, c, r_n, c_n;
    logic [2:0] beat, beat_n;
    logic [3:0] ka, ka_n, kb, kb_n;
    logic       issue;

    function automatic logic [9:0] tap_addr(input logic [3:0] rr, input logic [3:0] cc,
                                            input logic [3:0] k);
        logic [9:0] i, j;
        i = {6'd0, k} / 10'd3;
        j = {6'd0, k} % 10'd3;
        return ROW_W * ({6'd0, rr} + i) + COL_W * ({6'd0, cc} + j);
    endfunction

    assign tap_a = mem_rd1;
    assign tap_b = mem_rd2;
    assign issue = (state == S_ISSUE);

    // Beat b carries taps (2b, 2b+1); the odd fifth beat re-reads tap 8 on port b
    assign ka   = {1'b0, beat, 1'b0};
    assign kb   = (beat == LAST_BEAT) ? 4'd8 : ka + 4'd1;
    assign ka_n = {1'b0, beat_n, 1'b0};
    assign kb_n = (beat_n == LAST_BEAT) ? 4'd8 : ka_n + 4'd1;

    always_comb begin
        state_n = state;
        r_n     = r;
        c_n     = c;
        beat_n  = beat;
        case (state)
            S_IDLE: begin
                if (start && !busy) begin
                    state_n = S_WAIT;
                    r_n     = 4'd0;
                    c_n     = 4'd0;
                end
            end
            S_WAIT: begin
                if (win_ready) begin
                    state_n = S_ISSUE;
                    beat_n  = 3'd0;
                end
            end
            S_ISSUE: begin
                if (beat == LAST_BEAT) begin
                    if (r == LAST_POS && c == LAST_POS) begin
                        state_n = S_DRAIN;
                    end else begin
                        state_n = S_WAIT;
                        if (c == LAST_POS) begin
                            c_n = 4'd0;
                            r_n = r + 4'd1;
                        end else begin
                            c_n = c + 4'd1;
                        end
                    end
                end else begin
                    beat_n = beat + 3'd1;
                end
            end
            S_DRAIN: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Memory strobe/addresses are registered from next-state so they land in the issue cycle;
    // the beat sideband is registered from the issue cycle so it lines up with read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            r          <= 4'd0;
            c          <= 4'd0;
            beat       <= 3'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_load   <= 1'b0;
            mem_addr1  <= 10'd0;
            mem_addr2  <= 10'd0;
            beat_valid <= 1'b0;
            beat_first <= 1'b0;
            beat_last  <= 1'b0;
            b_valid    <= 1'b0;
            tap_idx_a  <= 4'd0;
            tap_idx_b  <= 4'd0;
            win_row    <= 4'd0;
            win_col    <= 4'd0;
        end else begin
            state      <= state_n;
            r          <= r_n;
            c          <= c_n;
            beat       <= beat_n;
            busy       <= (state_n != S_IDLE) || (state == S_DRAIN);
            done       <= (state == S_DRAIN);
            mem_load   <= (state_n == S_ISSUE);
            mem_addr1  <= (state_n == S_ISSUE) ? tap_addr(r_n, c_n, ka_n) : 10'd0;
            mem_addr2  <= (state_n == S_ISSUE) ? tap_addr(r_n, c_n, kb_n) : 10'd0;
            beat_valid <= issue;
            beat_first <= issue && (beat == 3'd0);
            beat_last  <= issue && (beat == LAST_BEAT);
            b_valid    <= issue && (beat != LAST_BEAT);
            tap_idx_a  <= issue ? ka : 4'd0;
            tap_idx_b  <= issue ? kb : 4'd0;
            if (issue) begin
                win_row <= r;
                win_col <= c;
            end
        end
    end
endmodule

// File: tb/tb_layer2_window_fetch.sv
// tb/tb_layer2_window_fetch.sv - scoreboard bench for layer2_window_fetch
`timescale 1ns/1ps
module tb_layer2_window_fetch;
    localparam int CH = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            win_ready = 1'b0;
    logic            busy, done, mem_load;
    logic [9:0]      mem_addr1, mem_addr2;
    logic [8*CH-1:0] mem_rd1 = '0, mem_rd2 = '0;
    logic            beat_valid, beat_first, beat_last, b_valid;
    logic [3:0]      tap_idx_a, tap_idx_b, win_row, win_col;
    logic [8*CH-1:0] tap_a, tap_b;
    logic [9:0]      a1q = '0, a2q = '0;

    int checks = 0;
    int errors = 0;
    int beats_seen = 0;

    typedef struct {
        int r;
        int c;
        int b;
    } beat_t;
    beat_t sb[$];

    layer2_window_fetch dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .win_ready(win_ready), .mem_load(mem_load),
        .mem_addr1(mem_addr1), .mem_addr2(mem_addr2),
        .mem_rd1(mem_rd1), .mem_rd2(mem_rd2),
        .beat_valid(beat_valid), .beat_first(beat_first), .beat_last(beat_last),
        .b_valid(b_valid), .tap_idx_a(tap_idx_a), .tap_idx_b(tap_idx_b),
        .win_row(win_row), .win_col(win_col), .tap_a(tap_a), .tap_b(tap_b)
    );

    always #5 clk = ~clk;

    // Result memory model: every channel returns the address low byte one cycle after the load
    always @(posedge clk) begin
        if (mem_load) begin
            mem_rd1 <= {CH{mem_addr1[7:0]}};
            mem_rd2 <= {CH{mem_addr2[7:0]}};
            a1q     <= mem_addr1;
            a2q     <= mem_addr2;
        end
    end

    wire [42:0] outs_cat = {busy, done, mem_load, mem_addr1, mem_addr2, beat_valid, beat_first,
                            beat_last, b_valid, tap_idx_a, tap_idx_b, win_row, win_col};

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_addr(input int r, input int c, input int k);
        return 56 * (r + k / 3) + 2 * (c + k % 3);
    endfunction

    task automatic push_frame();
        for (int r = 0; r < 12; r++)
            for (int c = 0; c < 12; c++)
                for (int b = 0; b < 5; b++)
                    sb.push_back('{r: r, c: c, b: b});
    endtask

    always @(negedge clk) begin
        beat_t      e;
        int         ka, kb;
        logic [9:0] ea, eb;
        if (!rst && beat_valid) begin
            beats_seen++;
            if (sb.size() == 0) begin
                check_val("sb_underflow", 1, 0);
            end else begin
                e  = sb.pop_front();
                ka = 2 * e.b;
                kb = (e.b == 4) ? 8 : ka + 1;
                ea = 10'(exp_addr(e.r, e.c, ka));
                eb = 10'(exp_addr(e.r, e.c, kb));
                check_val("win_pos", {win_row, win_col}, {4'(e.r), 4'(e.c)});
                check_val("tap_idx", {tap_idx_a, tap_idx_b}, {4'(ka), 4'(kb)});
                check_val("flags", {beat_first, beat_last, b_valid},
                          {e.b == 0, e.b == 4, e.b != 4});
                check_val("addr", {a1q, a2q}, {ea, eb});
                check_val("tap_data", {tap_a, tap_b}, {{CH{ea[7:0]}}, {CH{eb[7:0]}}});
                if (e.r == 0 && e.c == 0 && e.b == 0) check_val("w00_b0", {a1q, a2q}, {10'd0, 10'd2});
                if (e.r == 0 && e.c == 0 && e.b == 2) check_val("w00_b2", {a1q, a2q}, {10'd58, 10'd60});
                if (e.r == 0 && e.c == 0 && e.b == 4) check_val("w00_b4", {a1q, a2q}, {10'd116, 10'd116});
                if (e.r == 0 && e.c == 11 && e.b == 0) check_val("w0_11_b0", {a1q, a2q}, {10'd22, 10'd24});
                if (e.r == 1 && e.c == 0 && e.b == 0) check_val("w1_0_b0", {a1q, a2q}, {10'd56, 10'd58});
                if (e.r == 11 && e.c == 11 && e.b == 0) check_val("w11_11_b0", {a1q, a2q}, {10'd638, 10'd640});
                if (e.r == 11 && e.c == 11 && e.b == 4) check_val("w11_11_b4", {a1q, a2q}, {10'd754, 10'd754});
            end
        end
    end

    initial begin
        int rel, first_load, first_bv, done_cnt, done_rel, beats0, loads, bad;
        logic busy1, busy866, busy867;

        repeat (3) @(negedge clk);
        check_val("reset_outs", outs_cat, 43'd0);
        check_val("reset_tap_pass", {tap_a, tap_b}, {mem_rd1, mem_rd2});
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_val("idle_outs", outs_cat, 43'd0);

        // Frame A: win_ready held high, a stray start mid-frame
        push_frame();
        win_ready = 1'b1;
        beats0 = beats_seen;
        first_load = 0; first_bv = 0; done_cnt = 0; done_rel = 0;
        busy1 = 0; busy866 = 0; busy867 = 1;
        start = 1'b1;
        rel = 0;
        while (rel < 880) begin
            @(negedge clk);
            rel++;
            start = (rel == 100);
            if (rel == 1) busy1 = busy;
            if (rel == 866) busy866 = busy;
            if (rel == 867) busy867 = busy;
            if (mem_load && first_load == 0) first_load = rel;
            if (beat_valid && first_bv == 0) first_bv = rel;
            if (done) begin
                done_cnt++;
                done_rel = rel;
            end
        end
        check_val("a_busy_c1", busy1, 1);
        check_val("a_first_load", first_load, 2);
        check_val("a_first_beat", first_bv, 3);
        check_val("a_beats", beats_seen - beats0, 720);
        check_val("a_done_cnt", done_cnt, 1);
        check_val("a_done_cycle", done_rel, 866);
        check_val("a_busy_c866", busy866, 1);
        check_val("a_busy_c867", busy867, 0);
        check_val("a_sb_left", sb.size(), 0);

        // Frame B: 10 cycles of backpressure, then random win_ready
        push_frame();
        win_ready = 1'b0;
        beats0 = beats_seen;
        loads = 0; done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        rel = 0;
        while (done_cnt == 0 && rel < 20000) begin
            @(negedge clk);
            rel++;
            start = (rel == 37);
            if (rel <= 10 && mem_load) loads++;
            if (rel >= 10) win_ready = 1'($urandom_range(0, 1));
            if (done) done_cnt++;
        end
        check_val("b_backpressure_loads", loads, 0);
        check_val("b_done_seen", done_cnt, 1);
        check_val("b_beats", beats_seen - beats0, 720);
        check_val("b_sb_left", sb.size(), 0);

        // Reset mid-burst
        push_frame();
        win_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rel = 0;
        while (!mem_load && rel < 50) begin
            @(negedge clk);
            rel++;
        end
        check_val("r_load_seen", mem_load, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_val("r_async_outs", outs_cat, 43'd0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_load || done || busy || beat_valid) bad++;
        end
        check_val("r_quiet_after_abort", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
